// File: rtl/mem_sys_pkg.sv
// Shared definitions for the associative cache controller: state encoding,
// address field widths and the power-up contents of the main memory model.
package mem_sys_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMP    = 3'd1,
        WB      = 3'd2,
        FILL    = 3'd3,
        INSTALL = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam int TAG_W      = 5;
    localparam int IDX_W      = 8;
    localparam int OFF_W      = 3;
    localparam int LINE_WORDS = 4;

    // Word held at a never-written memory location.
    function automatic logic [15:0] mem_init_word(input logic [15:0] addr);
        return addr ^ 16'hA5A5;
    endfunction

endpackage

// File: rtl/cache.sv
// One cache way: 256 lines of four 16-bit words with per-line tag, valid and dirty.
// comp=1 compares against tag_in (writes only on hit); comp=0 is a raw line access.
module cache
    import mem_sys_pkg::*;
#(
    parameter int cache_id = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             createdump,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] offset,
    input  logic [15:0]      data_in,
    input  logic             comp,
    input  logic             write,
    input  logic             valid_in,
    output logic [TAG_W-1:0] tag_out,
    output logic [15:0]      data_out,
    output logic             hit,
    output logic             dirty,
    output logic             valid,
    output logic             err
);

    logic [15:0]             words [1<<IDX_W][LINE_WORDS];
    logic [TAG_W-1:0]        tags  [1<<IDX_W];
    logic [(1<<IDX_W)-1:0]   valid_bits;
    logic [(1<<IDX_W)-1:0]   dirty_bits;
    logic                    do_write;
    logic [7:0]              unused_id;
    logic                    unused_dump;

    assign unused_id   = 8'(cache_id);
    assign unused_dump = createdump;

    assign tag_out  = tags[index];
    assign data_out = words[index][offset[2:1]];
    assign valid    = valid_bits[index];
    assign dirty    = dirty_bits[index];
    assign hit      = enable & comp & valid & (tags[index] == tag_in);
    assign err      = enable & offset[0];
    assign do_write = enable & write & ~offset[0] & (~comp | hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (do_write) begin
            if (!comp) begin
                valid_bits[index] <= valid_in;
                dirty_bits[index] <= 1'b0;
            end else begin
                dirty_bits[index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            words[index][offset[2:1]] <= data_in;
            if (!comp) tags[index] <= tag_in;
        end
    end

endmodule

// File: rtl/four_bank_mem.sv
// Word-addressed main memory with a fixed read latency; locations never
// written since reset return mem_init_word(addr).
module four_bank_mem
    import mem_sys_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        createdump,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        err
);

    logic [15:0]         store [1<<15];
    logic [(1<<15)-1:0]  written;
    logic [15:0]         pipe  [RD_LAT];
    logic [14:0]         word_addr;
    logic [15:0]         rd_word;
    logic                unused_dump;

    assign unused_dump = createdump;
    assign word_addr   = addr[15:1];
    assign rd_word     = written[word_addr] ? store[word_addr]
                                            : mem_init_word({addr[15:1], 1'b0});
    assign data_out    = pipe[RD_LAT-1];
    assign stall       = 1'b0;
    assign err         = (rd | wr) & addr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            if (wr && !addr[0]) written[word_addr] <= 1'b1;
            pipe[0] <= rd ? rd_word : 16'h0000;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !addr[0]) store[word_addr] <= data_in;
    end

endmodule

// File: rtl/line_xfer_seq.sv
// Transfer counter for line write-back (4 cycles) and line fill (4+MEM_RD_LAT
// cycles); fill words land in the cache MEM_RD_LAT cycles after their read.
module line_xfer_seq
    import mem_sys_pkg::*;
#(
    parameter int MEM_RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wb_active,
    input  logic       fill_active,
    input  logic       stall,
    output logic [1:0] mem_off,
    output logic [1:0] cache_off,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       cache_rd,
    output logic       cache_wr,
    output logic       last
);

    localparam int FILL_CYCLES = LINE_WORDS + MEM_RD_LAT;
    localparam int CNT_W       = $clog2(FILL_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!(wb_active || fill_active)) begin
            count <= '0;
        end else if (!stall) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

    assign last = wb_active   ? (count == CNT_W'(LINE_WORDS - 1)) :
                  fill_active ? (count == CNT_W'(FILL_CYCLES - 1)) : 1'b0;

    assign mem_off   = count[1:0];
    // Modulo-4 subtraction gives the fill word currently leaving the memory pipe.
    assign cache_off = wb_active ? count[1:0] : count[1:0] - 2'(MEM_RD_LAT);
    assign mem_rd    = fill_active & (count < CNT_W'(LINE_WORDS));
    assign mem_wr    = wb_active;
    assign cache_rd  = wb_active;
    assign cache_wr  = fill_active & (count >= CNT_W'(MEM_RD_LAT)) & ~stall;

endmodule

// File: rtl/mem_system_assoc.sv
// Write-back, write-allocate controller over one or two cache ways and a
// four-bank memory, with pseudo-random victim choice when all ways are valid.
module mem_system_assoc
    import mem_sys_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int MEM_RD_LAT = 2,
    parameter int memtype    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam logic [1:0] WAY_MASK = (WAYS == 2) ? 2'b11 : 2'b01;

    state_t state, next_state;

    logic [15:0] addr_q, data_q;
    logic        wr_q, victim_ff, victim_q, victim_sel, hit_way, accept, illegal;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;

    logic [1:0]             way_en, way_hit, way_dirty, way_valid, way_err;
    logic [1:0][15:0]       way_data;
    logic [1:0][TAG_W-1:0]  way_tag;
    logic [OFF_W-1:0]       c_off;
    logic [15:0]            c_din;
    logic                   c_comp, c_write, req_err;

    logic        wb_active, fill_active, last;
    logic [1:0]  x_mem_off, x_cache_off;
    logic        x_cache_rd, x_cache_wr;
    logic [15:0] mem_addr, mem_data_out;
    logic        mem_rd, mem_wr, mem_stall, mem_err;

    assign tag_q      = addr_q[15:11];
    assign idx_q      = addr_q[10:3];
    assign accept     = (state == IDLE) & (Rd | Wr);
    assign illegal    = (Rd & Wr) | Addr[0];
    assign hit_way    = way_hit[1];
    assign victim_sel = !way_valid[0]                  ? 1'b0 :
                        (WAYS == 2 && !way_valid[1])   ? 1'b1 : victim_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            victim_ff <= 1'b0;
            victim_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q    <= Addr;
                data_q    <= DataIn;
                wr_q      <= Wr;
                victim_ff <= (WAYS == 2) ? ~victim_ff : 1'b0;
            end
            if (state == COMP) victim_q <= victim_sel;
        end
    end

    // Next state, cache way controls and request outputs.
    always_comb begin
        next_state  = state;
        way_en      = 2'b00;
        c_comp      = 1'b0;
        c_write     = 1'b0;
        c_off       = addr_q[2:0];
        c_din       = data_q;
        wb_active   = 1'b0;
        fill_active = 1'b0;
        Done        = 1'b0;
        CacheHit    = 1'b0;
        DataOut     = 16'h0000;
        req_err     = 1'b0;
        case (state)
            IDLE: begin
                if (Rd || Wr) next_state = illegal ? ERR : COMP;
            end
            COMP: begin
                way_en  = WAY_MASK;
                c_comp  = 1'b1;
                c_write = wr_q;
                if (|way_hit) begin
                    Done       = 1'b1;
                    CacheHit   = 1'b1;
                    DataOut    = way_data[hit_way];
                    next_state = IDLE;
                end else begin
                    next_state = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WB : FILL;
                end
            end
            WB: begin
                wb_active        = 1'b1;
                way_en[victim_q] = x_cache_rd;
                c_off            = {x_cache_off, 1'b0};
                if (last && !mem_stall) next_state = FILL;
            end
            FILL: begin
                fill_active      = 1'b1;
                way_en[victim_q] = x_cache_wr;
                c_write          = 1'b1;
                c_off            = {x_cache_off, 1'b0};
                c_din            = mem_data_out;
                if (last && !mem_stall) next_state = INSTALL;
            end
            INSTALL: begin
                way_en[victim_q] = 1'b1;
                c_comp           = 1'b1;
                c_write          = wr_q;
                Done             = 1'b1;
                DataOut          = way_data[victim_q];
                next_state       = IDLE;
            end
            ERR: begin
                Done       = 1'b1;
                req_err    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign Stall = (state != IDLE);
    assign err   = req_err | (Stall & ((|way_err) | mem_err));

    line_xfer_seq #(.MEM_RD_LAT(MEM_RD_LAT)) u_xfer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_active  (wb_active),
        .fill_active(fill_active),
        .stall      (mem_stall),
        .mem_off    (x_mem_off),
        .cache_off  (x_cache_off),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .cache_rd   (x_cache_rd),
        .cache_wr   (x_cache_wr),
        .last       (last)
    );

    assign mem_addr = wb_active ? {way_tag[victim_q], idx_q, x_mem_off, 1'b0}
                                : {tag_q,             idx_q, x_mem_off, 1'b0};

    for (genvar w = 0; w < 2; w++) begin : g_way
        if (w < WAYS) begin : g_inst
            cache #(.cache_id(2*memtype + w)) u_cache (
                .clk       (clk),
                .rst_n     (rst_n),
                .enable    (way_en[w]),
                .createdump(createdump),
                .tag_in    (tag_q),
                .index     (idx_q),
                .offset    (c_off),
                .data_in   (c_din),
                .comp      (c_comp),
                .write     (c_write),
                .valid_in  (1'b1),
                .tag_out   (way_tag[w]),
                .data_out  (way_data[w]),
                .hit       (way_hit[w]),
                .dirty     (way_dirty[w]),
                .valid     (way_valid[w]),
                .err       (way_err[w])
            );
        end else begin : g_tie
            assign way_tag[w]   = '0;
            assign way_data[w]  = '0;
            assign way_hit[w]   = 1'b0;
            assign way_dirty[w] = 1'b0;
            assign way_valid[w] = 1'b1;
            assign way_err[w]   = 1'b0;
        end
    end

    four_bank_mem #(.RD_LAT(MEM_RD_LAT)) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .createdump(createdump),
        .addr      (mem_addr),
        .data_in   (way_data[victim_q]),
        .wr        (mem_wr),
        .rd        (mem_rd),
        .data_out  (mem_data_out),
        .stall     (mem_stall),
        .err       (mem_err)
    );

endmodule

// File: tb/tb_mem_system_assoc.sv
// Directed bench for mem_system_assoc (2 ways, read latency 2): a vector table
// walked in order, then input-hold and reset-mid-fill sequences.
module tb_mem_system_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] Addr = '0, DataIn = '0;
    logic        Rd = 1'b0, Wr = 1'b0, createdump = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;

    int checks = 0;
    int passes = 0;
    int rd_seen = 0;
    logic [15:0] wr_log [$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_data;
        int          exp_lat;
        logic        exp_hit;
        logic        exp_err;
        int          exp_rd;
        int          exp_wr;
        logic [15:0] wb_base;
    } vec_t;

    vec_t vecs [12];

    mem_system_assoc #(.WAYS(2), .MEM_RD_LAT(2), .memtype(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .createdump(createdump),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory traffic observed mid-cycle.
    always @(negedge clk) begin
        if (dut.mem_rd) rd_seen++;
        if (dut.mem_wr) wr_log.push_back(dut.mem_addr);
    end

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] din, input logic [15:0] exp_data,
                                input int exp_lat, input logic exp_hit, input logic exp_err,
                                input int exp_rd, input int exp_wr, input logic [15:0] wb_base);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.din = din; v.exp_data = exp_data;
        v.exp_lat = exp_lat; v.exp_hit = exp_hit; v.exp_err = exp_err;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.wb_base = wb_base;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] din, input bit scramble,
                                 output int lat, output logic [15:0] data,
                                 output logic hit, output logic er);
        bit got = 0;
        lat = -1; data = '0; hit = 0; er = 0;
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (scramble) begin
                Addr   = 16'($urandom);
                DataIn = 16'($urandom);
            end
            if (Done) begin
                got = 1; lat = c; data = DataOut; hit = CacheHit; er = err;
            end
        end
        checkOutput("done_seen", int'(got), 1);
        if (got) begin
            @(negedge clk);
            checkOutput("done_single_pulse_and_stall_drop", int'({Done, Stall}), 0);
        end
        Addr = addr; DataIn = din;
    endtask

    initial begin
        int          lat, rd0, wr0;
        logic [15:0] data;
        logic        hit, er;

        vecs[0]  = mk(1, 0, 16'h0010, 16'h0000, 16'hA5B5,  8, 0, 0, 4, 0, 16'h0000);
        vecs[1]  = mk(1, 0, 16'h0010, 16'h0000, 16'hA5B5,  1, 1, 0, 0, 0, 16'h0000);
        vecs[2]  = mk(0, 1, 16'h0008, 16'h1234, 16'h0000,  8, 0, 0, 4, 0, 16'h0000);
        vecs[3]  = mk(1, 0, 16'h0808, 16'h0000, 16'hADAD,  8, 0, 0, 4, 0, 16'h0000);
        vecs[4]  = mk(1, 0, 16'h0008, 16'h0000, 16'h1234,  1, 1, 0, 0, 0, 16'h0000);
        vecs[5]  = mk(0, 1, 16'h080A, 16'hBEEF, 16'h0000,  1, 1, 0, 0, 0, 16'h0000);
        vecs[6]  = mk(1, 0, 16'h1008, 16'h0000, 16'hB5AD, 12, 0, 0, 4, 4, 16'h0808);
        vecs[7]  = mk(1, 0, 16'h080A, 16'h0000, 16'hBEEF, 12, 0, 0, 4, 4, 16'h0008);
        vecs[8]  = mk(1, 1, 16'h0020, 16'h0000, 16'h0000,  1, 0, 1, 0, 0, 16'h0000);
        vecs[9]  = mk(0, 1, 16'h0021, 16'h7777, 16'h0000,  1, 0, 1, 0, 0, 16'h0000);
        vecs[10] = mk(1, 0, 16'h0008, 16'h0000, 16'h1234,  8, 0, 0, 4, 0, 16'h0000);
        vecs[11] = mk(1, 0, 16'h1008, 16'h0000, 16'hB5AD,  8, 0, 0, 4, 0, 16'h0000);

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs", int'({DataOut, Done, Stall, CacheHit, err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rd0 = rd_seen;
            wr0 = wr_log.size();
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, 0,
                          lat, data, hit, er);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("v%0d_cachehit", i), int'(hit), int'(vecs[i].exp_hit));
            checkOutput($sformatf("v%0d_err", i), int'(er), int'(vecs[i].exp_err));
            if (vecs[i].rd && !vecs[i].wr)
                checkOutput($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_data));
            checkOutput($sformatf("v%0d_mem_reads", i), rd_seen - rd0, vecs[i].exp_rd);
            checkOutput($sformatf("v%0d_mem_writes", i), wr_log.size() - wr0, vecs[i].exp_wr);
            if (vecs[i].exp_wr > 0 && wr_log.size() - wr0 >= 4) begin
                checkOutput($sformatf("v%0d_wb_first_addr", i), int'(wr_log[wr0]),
                            int'(vecs[i].wb_base));
                checkOutput($sformatf("v%0d_wb_last_addr", i), int'(wr_log[wr0+3]),
                            int'(vecs[i].wb_base + 16'h0006));
            end
        end

        // Inputs wander during the miss; the captured request must win.
        applyStimulus(0, 1, 16'h0030, 16'h5555, 1, lat, data, hit, er);
        checkOutput("hold_write_latency", lat, 8);
        applyStimulus(1, 0, 16'h0030, 16'h0000, 0, lat, data, hit, er);
        checkOutput("hold_read_latency", lat, 1);
        checkOutput("hold_read_hit", int'(hit), 1);
        checkOutput("hold_read_data", int'(data), 16'h5555);

        // Reset asserted in the fourth FILL cycle of a clean miss.
        @(negedge clk);
        Rd = 1'b1; Addr = 16'h0040;
        @(posedge clk);
        #1 Rd = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("mid_fill_stall_before_reset", int'(Stall), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_fill_reset_outputs", int'({DataOut, Done, Stall, CacheHit, err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 16'h0040, 16'h0000, 0, lat, data, hit, er);
        checkOutput("after_reset_latency", lat, 8);
        checkOutput("after_reset_hit", int'(hit), 0);
        checkOutput("after_reset_data", int'(data), 16'hA5E5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_system_assoc.md
# mem_system_assoc

Parametrised write-back, write-allocate cache controller that sits between the processor's memory stage (or fetch stage) and the four-bank main memory. It manages one or two cache ways with per-line valid and dirty state, and selects victims pseudo-randomly. It sequences line write-back and line fill against a memory whose read latency is a parameter. It replaces the direct-mapped controller for both the instruction and data memory slots.

## Interface
- `WAYS`, default 2: number of ways; legal values 1 or 2. With 1, the block behaves direct-mapped.
- `MEM_RD_LAT`, default 2: cycles from a memory read request to valid `mem_data_out`.
- `memtype`, default 0: 0 for the instruction memory slot, 1 for the data memory slot. Way w is instantiated as cache `#(2*memtype + w)`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `Addr` input 16: byte address. Tag [15:11], index [10:3], offset [2:0].
- `DataIn` input 16: store data.
- `Rd` input 1: read request.
- `Wr` input 1: write request.
- `createdump` input 1: passed through to all cache and memory instances.
- `DataOut` output 16: read data; valid only while `Done`=1 on a read.
- `Done` output 1: one-cycle completion pulse.
- `Stall` output 1: high whenever the controller is not in IDLE.
- `CacheHit` output 1: high with `Done` only when the request hit in the COMP cycle.
- `err` output 1: request error, or a cache/memory error.

## Operation
- **Request acceptance:** a request is accepted in IDLE when `Rd|Wr`=1 and `Stall`=0. On acceptance, `Addr` and `DataIn` are captured into internal registers; later changes on the inputs are ignored.
- **Illegal request:** `Rd&Wr`=1, or `Addr[0]`=1 with any request, is illegal. The controller asserts `err`=1 and `Done`=1 in the next cycle, makes no cache or memory access, and returns to IDLE.
- **COMP state:** all ways are compare-accessed at the captured address.
  - Hit in way h: reads output that way's word. Writes update the word and set dirty. Then `Done`=1, `CacheHit`=1, and the next state is IDLE.
- **Victim selection on miss:**
  - The first invalid way is the victim, way 0 first.
  - If all ways are valid, the victim is given by `victim_ff`.
  - `victim_ff` toggles on every accepted request. It is held at 0 when `WAYS`=1.
- **Miss path:**
  - Victim valid and dirty: go to WB, else go to FILL.
- **WB state:** 4 cycles.
  - Word k (k = 0..3) is read from the victim way.
  - That word is written to memory at {victim tag, index, k, 0}.
- **FILL state:** 4+`MEM_RD_LAT` cycles.
  - Reads are issued for words 0..3 in cycles 0..3.
  - Word k is written into the victim way, with comp=0 and valid_in=1, in cycle k+`MEM_RD_LAT`.
- **INSTALL state:** the requested word is accessed with comp=1 in the victim way.
  - Read: `DataOut` is driven.
  - Write: `DataIn` is written and dirty is set.
  - `Done`=1, `CacheHit`=0, and the next state is IDLE.
- **Memory stall:** while `mem_stall`=1, the state, the transfer counter and all cache writes hold.
- **Error reporting:** `err` is also driven by the OR of the cache and memory err outputs, sampled while the controller is not in IDLE.

## Timing
- **Reset:** asynchronous; `rst_n` low forces the following immediately:
  - state IDLE, counter 0, `victim_ff` 0;
  - `DataOut` 0, `Done` 0, `Stall` 0, `CacheHit` 0, `err` 0.
  - A reset mid-WB or mid-FILL abandons the transfer; any partial line is left invalid.
- **Latencies, measured from the acceptance edge (request in cycle 0):**
  - Hit: `Done` in cycle 1.
  - Clean miss: `Done` in cycle 2+4+`MEM_RD_LAT` (cycle 8 with the default latency).
  - Dirty miss: `Done` in cycle 6+4+`MEM_RD_LAT` (cycle 12 with the default latency).
  - Each memory stall cycle adds one cycle to the latency.
- **`Done`:** exactly one pulse per accepted request. `Stall` falls in the cycle after `Done`.
- **Back-to-back requests:** a new request can be accepted in the cycle after `Done`.

## Structure
- **Shared package `mem_sys_pkg`:**
  - state encoding (IDLE, COMP, WB, FILL, INSTALL, ERR);
  - `TAG_W`=5, `IDX_W`=8, `OFF_W`=3, `LINE_WORDS`=4.
- **Sub-module `line_xfer_seq`**, parametrised by `MEM_RD_LAT`:
  - owns the transfer counter;
  - generates memory and cache word offsets, mem rd/wr and cache-write strobes for WB and FILL;
  - asserts `last` on the final transfer cycle;
  - freezes while stalled.
- **Instances:** `WAYS` cache instances and one four_bank_mem are instantiated in the top level. Per-way outputs are muxed by the hit or victim way.

## Test plan
- **Cold read miss then hit:** read 0x0010 after reset.
  - Expect `Done` at cycle 8 with `CacheHit`=0 and `DataOut` equal to the memory contents.
  - Repeating the read gives `Done` at cycle 1 with `CacheHit`=1 and the same data.
- **Two-way conflict:** write 0x1234 to 0x0008, then read 0x0808 (same index, different tag).
  - Both lines stay resident: a re-read of 0x0008 hits and returns 0x1234.
  - With `WAYS`=1, the re-read misses and 0x1234 is read back from memory.
- **Dirty eviction:** fill both ways of index 1 with dirty lines, then read a third tag.
  - Expect a WB of 4 memory writes to the line selected by `victim_ff`, and `Done` at cycle 12.
  - A later read of the evicted address returns the written data.
- **Illegal request:** `Rd`=`Wr`=1 at 0x0020 gives `err`=1 and `Done`=1 in cycle 1, with no memory activity. `Wr` at 0x0021 behaves the same.
- **Reset mid-fill:** pull `rst_n` low in FILL cycle 3.
  - All outputs read 0 immediately.
  - After reset, a read to the same address misses and completes correctly.
- **Input hold:** change `Addr` and `DataIn` every cycle during a miss. The result must match the values captured at acceptance.
